// File: rtl/piso_serializer_32bit.sv
// Parallel-in/serial-out transmitter with valid/ready on both the word load
// and the bit stream. Frames follow each other with no idle gap when the next
// word is offered during the last bit.
// Optional feature: define PISO_PARITY_EN to append one even-parity bit per
// frame (frame length WIDTH+1, ser_last marks the parity bit).
module piso_serializer_32bit #(
  parameter int unsigned WIDTH     = 32,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_in,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic             ser_ready,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             ser_first,
  output logic             ser_last,
  output logic             busy
);

`ifdef PISO_PARITY_EN
  localparam int unsigned N = WIDTH + 1;
`else
  localparam int unsigned N = WIDTH;
`endif
  localparam int unsigned CNT_W = $clog2(WIDTH + 2);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(N - 1);

  typedef enum logic {StIdle, StShift} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] sreg_q, sreg_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
`ifdef PISO_PARITY_EN
  logic             par_q, par_d;
`endif

  logic             shifting;
  logic             at_last;
  logic             load_acc;
  logic             bit_acc;
  logic             data_bit;
  logic             out_bit;
  logic [WIDTH-1:0] sreg_shifted;

  assign shifting   = (state_q == StShift);
  assign at_last    = shifting && (cnt_q == LAST_IDX);
  // A new word may be taken while the last bit of the current frame leaves.
  assign load_ready = !shifting || (at_last && ser_ready);
  assign load_acc   = load_valid && load_ready;
  assign bit_acc    = shifting && ser_ready;

  assign data_bit     = MSB_FIRST ? sreg_q[WIDTH-1] : sreg_q[0];
  assign sreg_shifted = MSB_FIRST ? {sreg_q[WIDTH-2:0], 1'b0} : {1'b0, sreg_q[WIDTH-1:1]};

`ifdef PISO_PARITY_EN
  // After WIDTH data bits the counter points at the parity slot.
  assign out_bit = (cnt_q == CNT_W'(WIDTH)) ? par_q : data_bit;
`else
  assign out_bit = data_bit;
`endif

  // Outputs are pure functions of registered state; gated so idle shows 0.
  assign ser_out   = shifting && out_bit;
  assign ser_valid = shifting;
  assign busy      = shifting;
  assign ser_first = shifting && (cnt_q == '0);
  assign ser_last  = at_last;

  // Next-state: load, shift on accepted bit, or return to idle after the last bit.
  always_comb begin
    state_d = state_q;
    sreg_d  = sreg_q;
    cnt_d   = cnt_q;
`ifdef PISO_PARITY_EN
    par_d   = par_q;
`endif
    case (state_q)
      StIdle: begin
        if (load_acc) begin
          state_d = StShift;
          sreg_d  = data_in;
          cnt_d   = '0;
`ifdef PISO_PARITY_EN
          par_d   = ^data_in;
`endif
        end
      end
      StShift: begin
        if (bit_acc) begin
          if (at_last) begin
            if (load_acc) begin
              sreg_d = data_in;
              cnt_d  = '0;
`ifdef PISO_PARITY_EN
              par_d  = ^data_in;
`endif
            end else begin
              state_d = StIdle;
              sreg_d  = '0;
              cnt_d   = '0;
            end
          end else begin
            sreg_d = sreg_shifted;
            cnt_d  = cnt_q + CNT_W'(1);
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers, cleared asynchronously so an abort takes effect at once.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      sreg_q  <= '0;
      cnt_q   <= '0;
`ifdef PISO_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      sreg_q  <= sreg_d;
      cnt_q   <= cnt_d;
`ifdef PISO_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

endmodule

// File: tb/tb_piso_serializer_32bit.sv
// Randomised and directed bench for piso_serializer_32bit. One MSB-first and
// one LSB-first instance share the same inputs; a frame-level model (word plus
// bit index) predicts every output each cycle.
module tb_piso_serializer_32bit;

  localparam int unsigned W = 32;
`ifdef PISO_PARITY_EN
  localparam int unsigned N = W + 1;
`else
  localparam int unsigned N = W;
`endif

  logic         clk = 1'b0;
  logic         reset;
  logic [W-1:0] data_in;
  logic         load_valid;
  logic         ser_ready;

  logic m_load_ready, m_ser_out, m_ser_valid, m_ser_first, m_ser_last, m_busy;
  logic l_load_ready, l_ser_out, l_ser_valid, l_ser_first, l_ser_last, l_busy;

  piso_serializer_32bit #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_m (
    .clk        (clk),
    .reset      (reset),
    .data_in    (data_in),
    .load_valid (load_valid),
    .load_ready (m_load_ready),
    .ser_ready  (ser_ready),
    .ser_out    (m_ser_out),
    .ser_valid  (m_ser_valid),
    .ser_first  (m_ser_first),
    .ser_last   (m_ser_last),
    .busy       (m_busy)
  );

  piso_serializer_32bit #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_l (
    .clk        (clk),
    .reset      (reset),
    .data_in    (data_in),
    .load_valid (load_valid),
    .load_ready (l_load_ready),
    .ser_ready  (ser_ready),
    .ser_out    (l_ser_out),
    .ser_valid  (l_ser_valid),
    .ser_first  (l_ser_first),
    .ser_last   (l_ser_last),
    .busy       (l_busy)
  );

  always #5 clk = ~clk;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  // Model: the frame in flight is a word plus the index of the bit on the wire.
  bit           act = 1'b0;
  logic [W-1:0] word = '0;
  int unsigned  idx = 0;
  bit           load_taken = 1'b0;
  int unsigned  vcount = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic frame_bit(input logic [W-1:0] w, input int unsigned i, input bit msb);
    if (i >= W) return ^w;
    return msb ? w[W-1-i] : w[i];
  endfunction

  task automatic check_outputs();
    logic lr_exp;
    lr_exp = !act || ((idx == N - 1) && ser_ready);
    check("m.ser_valid", m_ser_valid, act);
    check("m.busy", m_busy, act);
    check("m.load_ready", m_load_ready, lr_exp);
    check("m.ser_out", m_ser_out, act ? frame_bit(word, idx, 1'b1) : 1'b0);
    check("m.ser_first", m_ser_first, act && (idx == 0));
    check("m.ser_last", m_ser_last, act && (idx == N - 1));
    check("l.ser_valid", l_ser_valid, act);
    check("l.load_ready", l_load_ready, lr_exp);
    check("l.ser_out", l_ser_out, act ? frame_bit(word, idx, 1'b0) : 1'b0);
    check("l.ser_first", l_ser_first, act && (idx == 0));
    check("l.ser_last", l_ser_last, act && (idx == N - 1));
  endtask

  // One clock: update the model at the edge, check outputs on the falling edge.
  task automatic step();
    bit lr;
    @(posedge clk);
    load_taken = 1'b0;
    if (reset) begin
      lr = !act || ((idx == N - 1) && ser_ready);
      if (act && ser_ready) begin
        if (idx == N - 1) act = 1'b0;
        else idx++;
      end
      if (load_valid && lr) begin
        act        = 1'b1;
        word       = data_in;
        idx        = 0;
        load_taken = 1'b1;
      end
    end
    @(negedge clk);
    if (act) vcount++;
    check_outputs();
  endtask

  task automatic load_word(input logic [W-1:0] w);
    data_in    = w;
    load_valid = 1'b1;
    step();
    load_valid = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 200 && act; i++) step();
    check("idle_reached", act, 1'b0);
  endtask

  initial begin
    reset      = 1'b0;
    load_valid = 1'b1;
    data_in    = 32'hFFFF_FFFF;
    ser_ready  = 1'b1;
    #1;
    check_outputs();
    step();
    step();
    // Release away from the edge; nothing may start until a clock edge.
    reset      = 1'b1;
    load_valid = 1'b0;
    #1;
    check_outputs();

    // Basic frame
    vcount = 0;
    load_word(32'hA5A5_0F0F);
    wait_idle();
    check("basic_len", vcount, N);

    // Backpressure: stall five cycles while bit 10 is presented
    vcount = 0;
    load_word(32'h8000_0001);
    for (int i = 0; i < 100 && idx != 9; i++) step();
    check("bit10_reached", idx, 9);
    ser_ready = 1'b0;
    for (int i = 0; i < 5; i++) step();
    ser_ready = 1'b1;
    wait_idle();
    check("stall_len", vcount, N + 5);

    // Back-to-back frames
    vcount = 0;
    load_word(32'hFFFF_FFFF);
    for (int i = 0; i < 100 && !(act && idx == N - 1); i++) step();
    check("last_reached", idx, N - 1);
    load_word(32'h0000_0001);
    check("reload_taken", load_taken, 1'b1);
    wait_idle();
    check("b2b_len", vcount, 2 * N);

    // Abort at bit 16
    load_word(32'h1234_5678);
    for (int i = 0; i < 100 && idx != 15; i++) step();
    check("bit16_reached", idx, 15);
    reset = 1'b0;
    #1;
    act = 1'b0;
    idx = 0;
    check("abort.valid", m_ser_valid, 1'b0);
    check("abort.last", m_ser_last, 1'b0);
    step();
    reset = 1'b1;
    #1;
    check("abort.load_ready", m_load_ready, 1'b1);

    // Single set bit shows LSB-first vs MSB-first ordering
    load_word(32'h0000_0001);
    wait_idle();

`ifdef PISO_PARITY_EN
    load_word(32'h0000_0007);
    wait_idle();
    load_word(32'h0000_0003);
    wait_idle();
`endif

    // Random traffic; the producer holds an offered word until it is taken
    for (int i = 0; i < 3000; i++) begin
      ser_ready = ($urandom_range(0, 3) != 0);
      if (!(load_valid && !load_taken)) begin
        load_valid = ($urandom_range(0, 2) == 0);
        data_in    = $urandom;
      end
      if (load_taken) load_valid = 1'b0;
      step();
      if ($urandom_range(0, 999) == 0) begin
        reset = 1'b0;
        #1;
        act = 1'b0;
        idx = 0;
        check_outputs();
        step();
        reset = 1'b1;
      end
    end
    load_valid = 1'b0;
    ser_ready  = 1'b1;
    wait_idle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/piso_serializer_32bit.md
Name: piso_serializer_32bit

Overview:
- Parallel-in/serial-out transmitter. Accepts a WIDTH-bit word through a valid/ready load handshake and shifts it out one bit per accepted cycle on a valid/ready serial stream.
- It is the transmit-side counterpart of the team's parallel data registers and serial-to-parallel receivers, and sits between a word-wide producer and a bit-serial link.

Parameters:
- WIDTH, 32, word length in bits; legal range 2..64.
- MSB_FIRST, 1, 1 = bit WIDTH-1 is sent first; 0 = bit 0 is sent first.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous reset, active-low (0 = reset).
- data_in  input  WIDTH  word to send; sampled only on load handshake.
- load_valid  input  1  producer has a word on data_in.
- load_ready  output  1  block can accept a word this cycle.
- ser_ready  input  1  downstream accepts the current bit this cycle.
- ser_out  output  1  current serial bit (registered).
- ser_valid  output  1  ser_out holds a valid bit.
- ser_first  output  1  current bit is the first bit of a frame.
- ser_last  output  1  current bit is the last bit of a frame.
- busy  output  1  a frame is in progress (state SHIFT).

Behaviour:
- States:
  - IDLE: no frame.
  - SHIFT: frame in progress.
- Internal state: shift register sreg[WIDTH-1:0]; bit counter cnt of width $clog2(WIDTH+2).
- Reset (reset=0, takes effect immediately, no clock needed):
  - state=IDLE, sreg=0, cnt=0.
  - ser_out=0, ser_valid=0, ser_first=0, ser_last=0, busy=0.
  - load_ready=1 once state=IDLE.
- Frame length N = WIDTH (WIDTH+1 with PISO_PARITY_EN).
- Definitions:
  - load_ready = (state==IDLE) | (state==SHIFT & ser_last & ser_ready). This is combinational from registered state.
  - Load accept: load_valid & load_ready at a rising edge.
  - Bit accept: ser_valid & ser_ready at a rising edge.
- IDLE -> SHIFT on load accept:
  - sreg <= data_in, cnt <= 0.
  - Next cycle: ser_valid=1, ser_first=1, and ser_out = data_in[WIDTH-1] (MSB_FIRST=1) or data_in[0] (MSB_FIRST=0).
  - Latency from load accept to first bit on the wire: 1 cycle.
- SHIFT, on bit accept:
  - Shift sreg toward the output end and increment cnt.
  - ser_first drops after the first bit is accepted.
- SHIFT, ser_ready=0: all state and outputs hold. The bit is repeated until accepted.
- ser_last=1 exactly while cnt==N-1.
- On bit accept of the last bit:
  - With a simultaneous load accept: reload sreg, cnt <= 0, stay in SHIFT, ser_first=1 next cycle. There is no idle gap between frames.
  - Otherwise: go to IDLE; ser_valid, busy, ser_first and ser_last go to 0 next cycle; ser_out returns to 0.
- load_valid while load_ready=0 is ignored. The producer must hold it.
- data_in changes after load accept do not affect the frame in flight.
- Reset asserted mid-frame: the frame is aborted with no ser_last. After release the block is in IDLE with load_ready=1.
- ser_ready while ser_valid=0 has no effect.

Optional Feature:
- Macro PISO_PARITY_EN.
- Defined:
  - Frame is WIDTH data bits followed by one even-parity bit, so N=WIDTH+1.
  - The parity bit equals the XOR of all WIDTH bits captured at load, computed at load time and registered.
  - ser_last marks the parity bit.
- Undefined:
  - No parity logic; N=WIDTH.
  - ser_last marks the final data bit.

Test Plan:
- Reset: hold reset=0 with load_valid=1 and data_in=32'hFFFF_FFFF -> load_ready=1, ser_valid=0, ser_out=0, busy=0; no frame starts until reset=1 and a clock edge.
- Basic frame: WIDTH=32, MSB_FIRST=1, ser_ready=1, load 32'hA5A5_0F0F -> 32 consecutive valid cycles starting 1 cycle after load. The first 8 bits are 1,0,1,0,0,1,0,1 and the last 4 are 1,1,1,1. ser_first on bit 1, ser_last on bit 32, then ser_valid=0.
- Backpressure: load 32'h8000_0001, drop ser_ready for 5 cycles while bit 10 is presented -> ser_out and cnt hold, the frame takes 37 cycles, and the bit sequence is identical to the unstalled case.
- Back-to-back: load 32'hFFFF_FFFF, then present 32'h0000_0001 with load_valid during the ser_last cycle -> 64 contiguous ser_valid cycles, ser_first at cycle 33, final bit 1.
- Abort and LSB-first: drive reset=0 at bit 16 of a frame -> ser_valid=0 immediately, no ser_last; after release load_ready=1. With MSB_FIRST=0, load 32'h0000_0001 -> first bit 1, then 31 zeros.
- Parity (PISO_PARITY_EN): 32'h0000_0007 -> 33rd bit=1 with ser_last on it; 32'h0000_0003 -> 33rd bit=0.
